hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
//  Pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB). Decodes the ID-stage instruction
//  (opcode, rs1, rs2, rd per the R/I/S/B/U/J formats) and tracks in-flight destinations in EX/MEM/WB.
//  Drives stage enables, bubble/flush controls and EX operand-forward selects; counts stall cycles.
// PARAMETERS
//  CNT_W  16  width of saturating stall-cycle counter
// PORTS
//  clk            in   1      core clock, all state updates on rising edge
//  rst_n          in   1      synchronous active-low reset
//  id_valid       in   1      id_instr holds a real instruction (0 = bubble)
//  id_instr       in   32     instruction in ID stage
//  ex_redirect    in   1      EX resolved taken BRANCH / JAL / JALR (PC redirect this cycle)
//  mem_busy       in   1      data memory not ready; whole pipe must freeze
//  pc_en          out  1      PC register load enable
//  if_id_en       out  1      IF/ID register load enable
//  if_id_flush    out  1      IF/ID register load NOP
//  id_ex_flush    out  1      ID/EX register load NOP (bubble)
//  pipe_en        out  1      EX/MEM and MEM/WB load enable
//  fwd_a, fwd_b   out  2      EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
//  stall_count    out  CNT_W  hazard+freeze cycles since reset, saturates at all-ones
// BEHAVIOUR
//  Decode: writes_rd = opcode in {LUI,AUIPC,JAL,JALR,MEM_MISC,IMMEDIATE,REGISTER_LOGIC} && rd!=0.
//   uses_rs1 = {JALR,BRANCH,MEM_MISC,STORE_IMM,IMMEDIATE,REGISTER_LOGIC}; uses_rs2 = {BRANCH,STORE_IMM,
//   REGISTER_LOGIC}; is_load = MEM_MISC. Unknown opcode: no reads, no write. x0 never creates a hazard.
//  Tracker: per stage EX/MEM/WB regs {vld, rd, wr, ld} plus EX {rs1, rs2}; shifts when pipe_en=1;
//   EX entry loads from ID decode, or an invalid entry when id_ex_flush=1 or id_valid=0.
//  FSM states RUN, HAZ_STALL, FREEZE; priority per cycle: mem_busy > ex_redirect > data hazard.
//   RUN: all enables 1, flushes 0. mem_busy -> FREEZE. ex_redirect -> if_id_flush=1, id_ex_flush=1,
//     pc_en=1 (redirect loads), stay RUN; pending hazard in ID is discarded. hazard -> HAZ_STALL.
//   HAZ_STALL: pc_en=0, if_id_en=0, id_ex_flush=1, pipe_en=1; re-evaluates hazard each cycle against
//     the shifted tracker; clear -> RUN (instruction issues that cycle); ex_redirect overrides as in RUN.
//   FREEZE: pc_en=if_id_en=pipe_en=0, no flushes, tracker held; ex_redirect ignored (re-presented by
//     held EX); mem_busy=0 -> return to state held before freeze (RUN or HAZ_STALL).
//  Hazard decision and all enables are combinational from state + tracker + ID decode (0-cycle).
//  fwd_x for EX operand: 01 if MEM.wr && MEM.rd==EX.rsx; else 10 if WB.wr && WB.rd==EX.rsx; else 00.
//   MEM match takes priority over WB (newest value). Never forwards a load from MEM (prevented by stall).
//  stall_count += 1 each cycle in HAZ_STALL or FREEZE; holds at 2**CNT_W-1.
//  Reset (rst_n=0 at edge): state RUN, tracker all invalid, stall_count 0; thus pc_en=if_id_en=pipe_en=1,
//   flushes 0, fwd 00. Reset mid-stall/freeze aborts immediately; next cycle is RUN.
// CONFIGURATION
//  FORWARDING_EN defined: hazard = ID rsx matches EX.rd with EX.ld && EX.wr (load-use, 1-cycle stall);
//   fwd_a/fwd_b as above.
//  FORWARDING_EN undefined: hazard = ID rsx matches rd of any wr entry in EX, MEM or WB (regfile has no
//   write-through bypass; up to 3 stall cycles); fwd_a/fwd_b tied 00.
// TESTING
//  T1 rst_n=0 2 cycles, random inputs -> pc_en=if_id_en=pipe_en=1, flushes 0, fwd 00, stall_count 0.
//  T2 [FWD] lw x5,0(x1); add x6,x5,x2 -> 1 cycle pc_en=0,id_ex_flush=1; add reaches EX with fwd_a=10; count=1.
//  T3 [FWD] add x5,x1,x2; sub x7,x5,x5 -> no stall; sub in EX fwd_a=fwd_b=01; add x0,.. as producer -> fwd 00.
//  T4 lw x5 in EX, add x6,x5 in ID, ex_redirect=1 same cycle -> if_id_flush=id_ex_flush=1, pc_en=1, no stall.
//  T5 [FWD] T2 with mem_busy=1 for 3 cycles during stall -> all enables 0 for 3 cycles, then 1 stall cycle,
//     then issue; stall_count=4.
//  T6 [no FWD] add x5,x1,x2; add x6,x5,x3 -> 3 stall cycles, issue when producer leaves WB; fwd always 00.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Purpose     : ID-stage hazard detection, stage enable/flush sequencing and EX forward selects, 5-stage core.
// Latency     : every control output is combinational (0-cycle) from FSM state, the in-flight tracker and ID.
// Backpressure: mem_busy freezes every stage and the tracker; a RAW/load-use hazard holds PC and IF/ID and bubbles EX.
// Build option: FORWARDING_EN defined -> EX forwarding, only load-use stalls (1 cycle);
//               undefined (default)   -> no forwarding, stall until the producer has left WB (up to 3 cycles).
// Ports: clk, rst_n (sync, active-low); id_valid/id_instr = ID instruction; ex_redirect = taken control
//        transfer resolved in EX; mem_busy = data memory stall; pc_en, if_id_en, if_id_flush, id_ex_flush,
//        pipe_en = stage controls; fwd_a/fwd_b = EX operand select (00 RF, 01 EX/MEM, 10 MEM/WB);
//        stall_count = saturating count of cycles spent in HAZ_STALL or FREEZE.
module hazard_control_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [31:0]      id_instr,
   input  logic             ex_redirect,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             pipe_en,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [1:0] {
      S_RUN       = 2'd0,
      S_HAZ_STALL = 2'd1,
      S_FREEZE    = 2'd2
   } state_t;

   // One in-flight destination per downstream stage.
   typedef struct packed {
      logic       vld;
      logic       wr;
      logic [4:0] rd;
   } dst_t;

   // ---------------- ID decode ----------------
   logic [6:0] id_op;
   logic [4:0] id_rd;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_wr_op;
   logic       id_use1;
   logic       id_use2;
   logic       id_wr;
   logic [4:0] id_rs1_eff;
   logic [4:0] id_rs2_eff;
   logic       unused_funct;

   assign id_op  = id_instr[6:0];
   assign id_rd  = id_instr[11:7];
   assign id_rs1 = id_instr[19:15];
   assign id_rs2 = id_instr[24:20];
   // funct fields never influence hazards or forwarding.
   assign unused_funct = ^{id_instr[31:25], id_instr[14:12]};

   always_comb begin
      id_wr_op = 1'b0;
      id_use1  = 1'b0;
      id_use2  = 1'b0;
      case (id_op)
         OP_LUI, OP_AUIPC, OP_JAL: id_wr_op = 1'b1;
         OP_JALR, OP_LOAD, OP_IMM: begin
            id_wr_op = 1'b1;
            id_use1  = 1'b1;
         end
         OP_BRANCH, OP_STORE: begin
            id_use1 = 1'b1;
            id_use2 = 1'b1;
         end
         OP_REG: begin
            id_wr_op = 1'b1;
            id_use1  = 1'b1;
            id_use2  = 1'b1;
         end
         default: ;
      endcase
   end

   // x0 is never recorded as a destination, and unread source fields are forced to x0,
   // so neither can ever produce a match.
   assign id_wr      = id_wr_op && (id_rd != 5'd0);
   assign id_rs1_eff = id_use1 ? id_rs1 : 5'd0;
   assign id_rs2_eff = id_use2 ? id_rs2 : 5'd0;

   function automatic logic dst_hit(input dst_t d, input logic [4:0] rs);
      return d.vld && d.wr && (d.rd == rs);
   endfunction

   // ---------------- tracker / FSM state ----------------
   dst_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hazard;

`ifdef FORWARDING_EN
   logic       ex_ld_q, ex_ld_d;
   logic [4:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;

   // Only a load still in EX cannot be forwarded in time.
   assign hazard = id_valid && ex_ld_q &&
                   (dst_hit(ex_q, id_rs1_eff) || dst_hit(ex_q, id_rs2_eff));

   // MEM holds the newer value, so it wins over WB.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (dst_hit(mem_q, ex_rs1_q))     fwd_a = 2'b01;
      else if (dst_hit(wb_q, ex_rs1_q)) fwd_a = 2'b10;
      if (dst_hit(mem_q, ex_rs2_q))     fwd_b = 2'b01;
      else if (dst_hit(wb_q, ex_rs2_q)) fwd_b = 2'b10;
   end
`else
   // The register file has no write-through, so wait until the producer has retired from WB.
   assign hazard = id_valid &&
                   (dst_hit(ex_q, id_rs1_eff) || dst_hit(mem_q, id_rs1_eff) || dst_hit(wb_q, id_rs1_eff) ||
                    dst_hit(ex_q, id_rs2_eff) || dst_hit(mem_q, id_rs2_eff) || dst_hit(wb_q, id_rs2_eff));

   assign fwd_a = 2'b00;
   assign fwd_b = 2'b00;
`endif

   // Priority: mem_busy > ex_redirect > hazard. Leaving FREEZE needs no saved state: ID and the
   // tracker were held, so re-evaluating the hazard lands back in RUN or HAZ_STALL as before.
   always_comb begin
      state_d     = S_RUN;
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      pipe_en     = 1'b1;
      if (mem_busy) begin
         state_d  = S_FREEZE;
         pc_en    = 1'b0;
         if_id_en = 1'b0;
         pipe_en  = 1'b0;
      end else if (ex_redirect) begin
         // The redirect target loads into the PC; both younger instructions are squashed.
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (hazard) begin
         state_d     = S_HAZ_STALL;
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (pipe_en) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         ex_d  = '0;
         if (id_valid && !id_ex_flush) begin
            ex_d = '{vld: 1'b1, wr: id_wr, rd: id_rd};
         end
      end
   end

`ifdef FORWARDING_EN
   always_comb begin
      ex_ld_d  = ex_ld_q;
      ex_rs1_d = ex_rs1_q;
      ex_rs2_d = ex_rs2_q;
      if (pipe_en) begin
         ex_ld_d  = 1'b0;
         ex_rs1_d = 5'd0;
         ex_rs2_d = 5'd0;
         if (id_valid && !id_ex_flush) begin
            ex_ld_d  = (id_op == OP_LOAD);
            ex_rs1_d = id_rs1_eff;
            ex_rs2_d = id_rs2_eff;
         end
      end
   end
`endif

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q != S_RUN) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign stall_count = cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_RUN;
         ex_q     <= '0;
         mem_q    <= '0;
         wb_q     <= '0;
         cnt_q    <= '0;
`ifdef FORWARDING_EN
         ex_ld_q  <= 1'b0;
         ex_rs1_q <= 5'd0;
         ex_rs2_q <= 5'd0;
`endif
      end else begin
         state_q  <= state_d;
         ex_q     <= ex_d;
         mem_q    <= mem_d;
         wb_q     <= wb_d;
         cnt_q    <= cnt_d;
`ifdef FORWARDING_EN
         ex_ld_q  <= ex_ld_d;
         ex_rs1_q <= ex_rs1_d;
         ex_rs2_q <= ex_rs2_d;
`endif
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Purpose     : self-checking bench for hazard_control_unit (either FORWARDING_EN build).
// Latency     : outputs are checked in the same cycle the stimulus is applied.
// Backpressure: mem_busy windows are driven explicitly; all waits are plain clock edges.
module tb_hazard_control_unit;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

`ifdef FORWARDING_EN
   localparam int         HAZN  = 1;
   localparam logic [1:0] FW_WB = 2'b10;
`else
   localparam int         HAZN  = 3;
   localparam logic [1:0] FW_WB = 2'b00;
`endif

   // {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en}
   localparam logic [4:0] C_R = 5'b11001;
   localparam logic [4:0] C_S = 5'b00011;
   localparam logic [4:0] C_F = 5'b00000;
   localparam logic [4:0] C_D = 5'b11111;

   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_REG  = 7'b0110011;

   localparam logic [6:0] OPS [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                       7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111};
   // {writes_rd, uses_rs2, uses_rs1} per opcode above
   localparam logic [2:0] USE [10] = '{3'b100, 3'b100, 3'b100, 3'b101, 3'b011,
                                       3'b101, 3'b011, 3'b101, 3'b111, 3'b000};

   typedef struct packed {
      logic [4:0] ctl;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             id_valid = 1'b0;
   logic [31:0]      id_instr = 32'd0;
   logic             ex_redirect = 1'b0;
   logic             mem_busy = 1'b0;
   logic             pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_count;

   int   n_chk = 0;
   int   n_bad = 0;
   int   exp_cnt = 0;
   logic st_nonrun = 1'b0;
   logic prev_held = 1'b0;
   exp_t exp_q[$];

   hazard_control_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
      .ex_redirect(ex_redirect), .mem_busy(mem_busy), .pc_en(pc_en), .if_id_en(if_id_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pipe_en(pipe_en),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @%0t got=%0h want=%0h", tag, $time, got, want);
      end
   endtask

   task automatic cmp_out(input exp_t e);
      chk("pc_en",       32'(pc_en),       32'(e.ctl[4]));
      chk("if_id_en",    32'(if_id_en),    32'(e.ctl[3]));
      chk("if_id_flush", 32'(if_id_flush), 32'(e.ctl[2]));
      chk("id_ex_flush", 32'(id_ex_flush), 32'(e.ctl[1]));
      chk("pipe_en",     32'(pipe_en),     32'(e.ctl[0]));
      chk("fwd_a",       32'(fwd_a),       32'(e.fa));
      chk("fwd_b",       32'(fwd_b),       32'(e.fb));
      chk("stall_count", 32'(stall_count), 32'(exp_cnt));
   endtask

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, op};
   endfunction

   // One cycle: the counter advances at the edge if the cycle just ended sat in HAZ_STALL/FREEZE,
   // and the new cycle is in one of those states if the previous decision held the PC.
   task automatic step(input logic v, input logic [31:0] ins, input logic rdr, input logic busy,
                       input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      @(posedge clk);
      if (st_nonrun && exp_cnt < CNT_MAX) exp_cnt++;
      st_nonrun = prev_held;
      #1;
      id_valid = v; id_instr = ins; ex_redirect = rdr; mem_busy = busy;
      exp_q.push_back('{ctl: ctl, fa: fa, fb: fb});
      @(negedge clk);
      e = exp_q.pop_front();
      cmp_out(e);
      prev_held = !ctl[4];
   endtask

   task automatic bub(input logic [1:0] fa, input logic [1:0] fb);
      step(1'b0, 32'd0, 1'b0, 1'b0, C_R, fa, fb);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) begin
         id_valid = 1'($urandom_range(0, 1)); id_instr = $urandom;
         ex_redirect = 1'($urandom_range(0, 1)); mem_busy = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      rst_n = 1'b1; id_valid = 1'b0; id_instr = 32'd0; ex_redirect = 1'b0; mem_busy = 1'b0;
      exp_cnt = 0; st_nonrun = 1'b0; prev_held = 1'b0;
      @(negedge clk);
      cmp_out('{ctl: C_R, fa: 2'b00, fb: 2'b00});
   endtask

   // Producer lw x5 issues, then cons; stalls only if cons reads x5. fa/fb expected with cons in EX.
   task automatic dep_chain(input logic [31:0] cons, input logic hz, input logic [1:0] fa, input logic [1:0] fb);
      step(1'b1, mk(OP_LOAD, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      if (hz) repeat (HAZN) step(1'b1, cons, 1'b0, 1'b0, C_S, 2'b00, 2'b00);
      step(1'b1, cons, 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      bub(fa, fb);
      bub(2'b00, 2'b00);
      bub(2'b00, 2'b00);
   endtask

   initial begin
      logic [31:0] lw5, use5;
      logic [2:0]  u;
      lw5  = mk(OP_LOAD, 5'd5, 5'd1, 5'd0);
      use5 = mk(OP_REG, 5'd6, 5'd5, 5'd2);

      do_reset();

      // load-use with a 3-cycle mem_busy window; a redirect while frozen is ignored
      step(1'b1, lw5,  1'b0, 1'b0, C_R, 2'b00, 2'b00);
      step(1'b1, use5, 1'b0, 1'b1, C_F, 2'b00, 2'b00);
      step(1'b1, use5, 1'b1, 1'b1, C_F, 2'b00, 2'b00);
      step(1'b1, use5, 1'b0, 1'b1, C_F, 2'b00, 2'b00);
      repeat (HAZN) step(1'b1, use5, 1'b0, 1'b0, C_S, 2'b00, 2'b00);
      step(1'b1, use5, 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      bub(FW_WB, 2'b00);
      bub(2'b00, 2'b00);
      bub(2'b00, 2'b00);

      // redirect in the same cycle as a load-use hazard
      step(1'b1, lw5,  1'b0, 1'b0, C_R, 2'b00, 2'b00);
      step(1'b1, use5, 1'b1, 1'b0, C_D, 2'b00, 2'b00);
      repeat (3) bub(2'b00, 2'b00);

      // redirect once already stalling
      step(1'b1, lw5,  1'b0, 1'b0, C_R, 2'b00, 2'b00);
      step(1'b1, use5, 1'b0, 1'b0, C_S, 2'b00, 2'b00);
      step(1'b1, use5, 1'b1, 1'b0, C_D, 2'b00, 2'b00);
      repeat (3) bub(2'b00, 2'b00);

      // per-opcode source usage
      for (int i = 0; i < 10; i++) begin
         u = USE[i];
         dep_chain(mk(OPS[i], 5'd7, 5'd5, 5'd0), u[0], u[0] ? FW_WB : 2'b00, 2'b00);
         dep_chain(mk(OPS[i], 5'd7, 5'd0, 5'd5), u[1], 2'b00, u[1] ? FW_WB : 2'b00);
      end

`ifdef FORWARDING_EN
      // ALU result forwarded from MEM to both operands
      step(1'b1, mk(OP_REG, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      step(1'b1, mk(OP_REG, 5'd7, 5'd5, 5'd5), 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      bub(2'b01, 2'b01);
      repeat (2) bub(2'b00, 2'b00);
      // x0 producer never forwards
      step(1'b1, mk(OP_REG, 5'd0, 5'd1, 5'd2), 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      step(1'b1, mk(OP_REG, 5'd7, 5'd0, 5'd0), 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      repeat (3) bub(2'b00, 2'b00);
      // two writers of x5: the MEM copy is newer
      step(1'b1, mk(OP_REG, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      step(1'b1, mk(OP_REG, 5'd5, 5'd3, 5'd4), 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      step(1'b1, mk(OP_REG, 5'd6, 5'd5, 5'd5), 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      bub(2'b01, 2'b01);
      repeat (2) bub(2'b00, 2'b00);
`else
      // ALU producer: stall until it leaves WB
      step(1'b1, mk(OP_REG, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      repeat (3) step(1'b1, mk(OP_REG, 5'd6, 5'd5, 5'd3), 1'b0, 1'b0, C_S, 2'b00, 2'b00);
      step(1'b1, mk(OP_REG, 5'd6, 5'd5, 5'd3), 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      repeat (3) bub(2'b00, 2'b00);
      // per-opcode destination write, x0 destination included
      for (int i = 0; i < 11; i++) begin
         if (i < 10) begin
            u = USE[i];
            step(1'b1, mk(OPS[i], 5'd5, 5'd0, 5'd0), 1'b0, 1'b0, C_R, 2'b00, 2'b00);
         end else begin
            u = 3'b000;
            step(1'b1, mk(OP_REG, 5'd0, 5'd1, 5'd2), 1'b0, 1'b0, C_R, 2'b00, 2'b00);
         end
         if (u[2]) repeat (3) step(1'b1, mk(OP_REG, 5'd6, 5'd5, 5'd0), 1'b0, 1'b0, C_S, 2'b00, 2'b00);
         step(1'b1, mk(OP_REG, 5'd6, (i < 10) ? 5'd5 : 5'd0, 5'd0), 1'b0, 1'b0, C_R, 2'b00, 2'b00);
         repeat (3) bub(2'b00, 2'b00);
      end
`endif

      // reset while stalling clears the tracker
      step(1'b1, lw5,  1'b0, 1'b0, C_R, 2'b00, 2'b00);
      step(1'b1, use5, 1'b0, 1'b0, C_S, 2'b00, 2'b00);
      do_reset();
      step(1'b1, use5, 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      bub(2'b00, 2'b00);

      // reset while frozen
      step(1'b1, lw5,  1'b0, 1'b0, C_R, 2'b00, 2'b00);
      step(1'b1, use5, 1'b0, 1'b1, C_F, 2'b00, 2'b00);
      do_reset();
      step(1'b1, use5, 1'b0, 1'b0, C_R, 2'b00, 2'b00);
      bub(2'b00, 2'b00);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
